// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers and default pointer width shared by the Gray FIFO stages.
package gray_pkg;
  localparam int PTR_W_DEF = 4;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  // Prefix-XOR from the MSB down; zero-extended upper bits make this correct for any width up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: STAGES-deep, W-wide flop chain that brings a Gray pointer into the local clock domain.
module gray_sync #(
  parameter int W = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s [STAGES];
  always_ff @(posedge clk) begin
    if (reset) r_s <= '{default: '0};
    else begin
      r_s[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_s[i] <= r_s[i-1];
    end
  end
  assign o_q = r_s[STAGES-1];
endmodule

// File: rtl/gray_rd_ptr_sync.sv
// gray_rd_ptr_sync: read-side pointer logic; syncs the Gray write pointer and tracks read pointer,
// occupancy, empty and a sticky overflow flag.
module gray_rd_ptr_sync
  import gray_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] wr_ptr_gray,
  input  logic             rd_en,
  output logic             rd_fire,
  output logic [PTR_W-2:0] rd_addr,
  output logic [PTR_W-1:0] rd_ptr_gray,
  output logic [PTR_W-1:0] level,
  output logic             empty,
  output logic             ovf_err
);
  localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** (PTR_W - 1));
  logic [PTR_W-1:0] w_sync, w_wbin, w_rbin_next, w_level_next;
  logic [PTR_W-1:0] r_rbin, r_gray, r_level;
  logic             r_empty, r_ovf;
  gray_sync #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (wr_ptr_gray),
    .o_q  (w_sync)
  );
  assign w_wbin       = PTR_W'(gray2bin(32'(w_sync)));
  assign rd_fire      = rd_en & ~r_empty;
  assign w_rbin_next  = r_rbin + PTR_W'(rd_fire);
  assign w_level_next = w_wbin - w_rbin_next;
  // empty is derived from the same next-level as level, so it is conservative while the sync chain lags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rbin  <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_gray  <= PTR_W'(bin2gray(32'(w_rbin_next)));
      r_level <= w_level_next;
      r_empty <= w_level_next == '0;
      r_ovf   <= r_ovf | (w_level_next > DEPTH);
    end
  end
  assign rd_addr     = r_rbin[PTR_W-2:0];
  assign rd_ptr_gray = r_gray;
  assign level       = r_level;
  assign empty       = r_empty;
  assign ovf_err     = r_ovf;
endmodule

// File: tb/tb_gray_rd_ptr_sync.sv
// tb_gray_rd_ptr_sync: randomized + directed scoreboard bench against a count-based reference model.
module tb_gray_rd_ptr_sync;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] wr_ptr_gray = '0;
  logic       rd_en = 1'b0;
  logic       rd_fire;
  logic [2:0] rd_addr;
  logic [3:0] rd_ptr_gray;
  logic [3:0] level;
  logic       empty;
  logic       ovf_err;

  gray_rd_ptr_sync #(.PTR_W(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_en      (rd_en),
    .rd_fire    (rd_fire),
    .rd_addr    (rd_addr),
    .rd_ptr_gray(rd_ptr_gray),
    .level      (level),
    .empty      (empty),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fk;
    bit fire;
    int addr;
    int gray;
    int lvl;
    bit emp;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  int   drv[$];
  int   rcnt = 0, m_lvl = 0, last_rst = -100, cyc = 0;
  bit   m_emp = 1'b1, m_ovf = 1'b0, known = 1'b0;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  // Model: write count seen locally is the count driven two edges earlier, unless a reset intervened.
  task automatic step(input bit rst, input int w, input bit rd);
    exp_t e;
    int   wv, wvis;
    @(negedge clk);
    wv = w & 15;
    reset = rst;
    rd_en = rd;
    wr_ptr_gray = 4'(wv ^ (wv >> 1));
    drv.push_back(wv);
    e.fk = known;
    e.fire = rd && !m_emp;
    if (rst) begin
      rcnt = 0; m_lvl = 0; m_emp = 1'b1; m_ovf = 1'b0; known = 1'b1; last_rst = cyc;
    end else begin
      rcnt = (rcnt + int'(e.fire)) % 16;
      wvis = (cyc - 2 > last_rst) ? drv[cyc-2] : 0;
      m_lvl = (wvis - rcnt + 16) % 16;
      m_emp = (m_lvl == 0);
      if (m_lvl > 8) m_ovf = 1'b1;
    end
    e.addr = rcnt % 8;
    e.gray = rcnt ^ (rcnt >> 1);
    e.lvl = m_lvl;
    e.emp = m_emp;
    e.ovf = m_ovf;
    sb.push_back(e);
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    logic f;
    forever begin
      @(negedge clk);
      #3 f = rd_fire;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.fk) chk("rd_fire", 8'(f), 8'(e.fire));
        chk("rd_addr", 8'(rd_addr), 8'(e.addr));
        chk("rd_ptr_gray", 8'(rd_ptr_gray), 8'(e.gray));
        chk("level", 8'(level), 8'(e.lvl));
        chk("empty", 8'(empty), 8'(e.emp));
        chk("ovf_err", 8'(ovf_err), 8'(e.ovf));
      end
    end
  end

  initial begin : driver
    int w;
    repeat (2) step(1'b1, 0, 1'b1);
    repeat (4) step(1'b0, 1, 1'b0);
    repeat (4) step(1'b0, 3, 1'b0);
    repeat (4) step(1'b0, 3, 1'b1);
    for (int i = 4; i <= 15; i++) step(1'b0, i, 1'b1);
    repeat (6) step(1'b0, 15, 1'b1);
    repeat (2) step(1'b0, 15, 1'b0);
    repeat (3) step(1'b0, 16, 1'b0);
    step(1'b0, 16, 1'b1);
    repeat (2) step(1'b0, 16, 1'b0);
    step(1'b1, 0, 1'b0);
    repeat (4) step(1'b0, 9, 1'b0);
    repeat (4) step(1'b0, 2, 1'b0);
    step(1'b1, 0, 1'b0);
    repeat (4) step(1'b0, 5, 1'b0);
    step(1'b1, 5, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);
    w = 0;
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) begin
        w = 0;
        step(1'b1, 0, 1'($urandom_range(0, 1)));
      end else begin
        w = w + int'($urandom_range(0, 1)) + (($urandom_range(0, 49) == 0) ? 6 : 0);
        step(1'b0, w, 1'($urandom_range(0, 2) != 0));
      end
    end
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
